inst_fetch: RTL and testbench

Instruction fetch stage of the 6502 core, directly upstream of `prime_decoder`. It reads the opcode byte from program memory and presents it to the decoder, which returns the instruction length. It then reads the 0–2 operand bytes and hands the complete instruction to the decoder/execute side over a valid/ready handshake. It owns the program counter for sequential flow and accepts a redirect (branch, jump, interrupt) from execute.

---
 rtl/inst_fetch.sv | 184 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: 6502 fetch stage; reads opcode + 0..2 operand bytes, presents a whole instruction.
// Latency: opcode read to inst_valid is 2/4/6 cycles for 1/2/3-byte instructions.
// Backpressure: holds the instruction stable in PRESENT (no memory reads) until inst_ready.
//
// Ports:
//   clk, rst               core clock, synchronous active-high reset
//   mem_rd/mem_addr        read strobe and address; mem_rdata returns one cycle later
//   dec_opcode/dec_len     opcode to the length decoder, combinational length back (0 means 1)
//   redirect_valid/_pc     flush and restart fetch at redirect_pc (highest priority after rst)
//   inst_valid/inst_ready  instruction handshake; inst_opcode/op1/op2/len/pc carry the instruction
//
// Build option: define INST_FETCH_VECTOR_EN to fetch the start address from the reset vector
// at 16'hFFFC/16'hFFFD instead of starting at RESET_PC.
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0400
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  dec_opcode,
    input  logic [1:0]  dec_len,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [7:0]  inst_opcode,
    output logic [7:0]  inst_op1,
    output logic [7:0]  inst_op2,
    output logic [1:0]  inst_len,
    output logic [15:0] inst_pc
);

    typedef enum logic [3:0] {
        S_OP_REQ  = 4'd0,
        S_OP_CAP  = 4'd1,
        S_B1_REQ  = 4'd2,
        S_B1_CAP  = 4'd3,
        S_B2_REQ  = 4'd4,
        S_B2_CAP  = 4'd5,
        S_PRESENT = 4'd6,
        S_VLO_REQ = 4'd7,
        S_VLO_CAP = 4'd8,
        S_VHI_REQ = 4'd9,
        S_VHI_CAP = 4'd10
    } state_t;

`ifdef INST_FETCH_VECTOR_EN
    localparam state_t RST_STATE = S_VLO_REQ;
`else
    localparam state_t RST_STATE = S_OP_REQ;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [7:0]  r_opcode;
    logic [7:0]  r_op1;
    logic [7:0]  r_op2;
    logic [1:0]  r_len;
    logic [15:0] r_inst_pc;
    logic [1:0]  w_cap_len;

    // The decoder reports 0 for opcodes it does not know; fetch them as 1-byte.
    assign w_cap_len = (dec_len == 2'd0) ? 2'd1 : dec_len;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a redirect restarts at OP_REQ from any state, vector states included.
    always_comb begin
        w_next = r_state;
        if (redirect_valid) begin
            w_next = S_OP_REQ;
        end else begin
            case (r_state)
                S_OP_REQ:  w_next = S_OP_CAP;
                S_OP_CAP:  w_next = (w_cap_len == 2'd1) ? S_PRESENT : S_B1_REQ;
                S_B1_REQ:  w_next = S_B1_CAP;
                S_B1_CAP:  w_next = (r_len == 2'd3) ? S_B2_REQ : S_PRESENT;
                S_B2_REQ:  w_next = S_B2_CAP;
                S_B2_CAP:  w_next = S_PRESENT;
                S_PRESENT: w_next = inst_ready ? S_OP_REQ : S_PRESENT;
`ifdef INST_FETCH_VECTOR_EN
                S_VLO_REQ: w_next = S_VLO_CAP;
                S_VLO_CAP: w_next = S_VHI_REQ;
                S_VHI_REQ: w_next = S_VHI_CAP;
                S_VHI_CAP: w_next = S_OP_REQ;
`endif
                default:   w_next = S_OP_REQ;
            endcase
        end
    end

    // Output logic; everything towards memory and the consumer is forced quiet while rst is high.
    always_comb begin
        mem_rd     = 1'b0;
        mem_addr   = 16'h0000;
        inst_valid = 1'b0;
        dec_opcode = 8'h00;
        if (!rst) begin
            dec_opcode = r_opcode;
            case (r_state)
                S_OP_REQ: begin
                    mem_rd   = 1'b1;
                    mem_addr = r_pc;
                end
                // Bypass so the length is known in the same cycle the opcode arrives.
                S_OP_CAP: dec_opcode = mem_rdata;
                S_B1_REQ: begin
                    mem_rd   = 1'b1;
                    mem_addr = r_pc + 16'd1;
                end
                S_B2_REQ: begin
                    mem_rd   = 1'b1;
                    mem_addr = r_pc + 16'd2;
                end
                S_PRESENT: inst_valid = 1'b1;
`ifdef INST_FETCH_VECTOR_EN
                S_VLO_REQ: begin
                    mem_rd   = 1'b1;
                    mem_addr = 16'hFFFC;
                end
                S_VHI_REQ: begin
                    mem_rd   = 1'b1;
                    mem_addr = 16'hFFFD;
                end
`endif
                default: ;
            endcase
        end
    end

    // Datapath: pc and instruction registers. A redirect discards any returning read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_opcode  <= 8'h00;
            r_op1     <= 8'h00;
            r_op2     <= 8'h00;
            r_len     <= 2'd0;
            r_inst_pc <= 16'h0000;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else begin
            case (r_state)
                S_OP_CAP: begin
                    r_opcode  <= mem_rdata;
                    r_len     <= w_cap_len;
                    r_op1     <= 8'h00;
                    r_op2     <= 8'h00;
                    r_inst_pc <= r_pc;
                end
                S_B1_CAP: r_op1 <= mem_rdata;
                S_B2_CAP: r_op2 <= mem_rdata;
                S_PRESENT: begin
                    if (inst_ready) begin
                        r_pc <= r_pc + {14'd0, r_len};
                    end
                end
`ifdef INST_FETCH_VECTOR_EN
                // The vector is assembled directly in the pc register.
                S_VLO_CAP: r_pc[7:0]  <= mem_rdata;
                S_VHI_CAP: r_pc[15:8] <= mem_rdata;
`endif
                default: ;
            endcase
        end
    end

    assign inst_opcode = r_opcode;
    assign inst_op1    = r_op1;
    assign inst_op2    = r_op2;
    assign inst_len    = r_len;
    assign inst_pc     = r_inst_pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [15:0] RESET_PC = 16'h0400;
`ifdef INST_FETCH_VECTOR_EN
    localparam logic [15:0] START = 16'hC000;
    localparam int VEC = 4;
`else
    localparam logic [15:0] START = RESET_PC;
    localparam int VEC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  dec_opcode;
    logic [1:0]  dec_len;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [7:0]  inst_opcode, inst_op1, inst_op2;
    logic [1:0]  inst_len;
    logic [15:0] inst_pc;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dec_opcode(dec_opcode), .dec_len(dec_len),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_opcode(inst_opcode), .inst_op1(inst_op1), .inst_op2(inst_op2),
        .inst_len(inst_len), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [1:0]  len;
        logic [15:0] pc;
    } exp_t;

    logic [7:0] mem [0:65535];
    exp_t       q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    bit         mon_en = 0;

    // Reference model: the current fetch started m_age cycles ago at m_pc; byte k of an
    // L-byte instruction is read 2k cycles after the start and the instruction shows at 2L.
    logic [15:0] m_pc = RESET_PC;
    int          m_age = 0;
    int          m_vec = VEC;

    function automatic logic [1:0] len_of(input logic [7:0] op);
        case (op)
            8'hEA, 8'hE8: len_of = 2'd1;
            8'hAD, 8'h4C: len_of = 2'd3;
            8'hA9:        len_of = 2'd2;
            default:      len_of = op[1:0];
        endcase
    endfunction

    function automatic int norm_len(input logic [15:0] pc);
        logic [1:0] l;
        l = len_of(mem[pc]);
        norm_len = (l == 2'd0) ? 1 : int'(l);
    endfunction

    assign dec_len = len_of(dec_opcode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Memory: answers one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        logic        rd_q;
        logic [15:0] a_q;
        rd_q = mem_rd;
        a_q  = mem_addr;
        #1;
        mem_rdata = rd_q ? mem[a_q] : 8'($urandom);
    end

    // Model update at each edge from the inputs driven that cycle.
    always @(posedge clk) begin
        int   l0;
        bit   v0;
        exp_t e;
        l0 = norm_len(m_pc);
        v0 = (m_vec == 0) && (m_age >= 2 * l0);
        if (rst) begin
            m_pc = RESET_PC; m_age = 0; m_vec = VEC; q.delete();
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_age = 0; m_vec = 0; q.delete();
        end else if (m_vec > 0) begin
            m_vec--;
            if (m_vec == 0) m_pc = {mem[16'hFFFD], mem[16'hFFFC]};
        end else if (v0 && inst_ready) begin
            m_pc = m_pc + 16'(l0); m_age = 0;
        end else if (m_age < 2 * l0) begin
            m_age++;
            if (m_age == 2 * l0) begin
                e.op  = mem[m_pc];
                e.op1 = (l0 >= 2) ? mem[m_pc + 16'd1] : 8'h00;
                e.op2 = (l0 == 3) ? mem[m_pc + 16'd2] : 8'h00;
                e.len = 2'(l0);
                e.pc  = m_pc;
                q.push_back(e);
            end
        end
    end

    // Monitor: memory traffic and valid every cycle, fields against the scoreboard head.
    always @(negedge clk) begin
        int          l;
        int          ph;
        logic        e_rd, e_vld;
        logic [15:0] e_addr;
        if (mon_en) begin
            l = norm_len(m_pc);
            e_rd = 0; e_vld = 0; e_addr = 16'h0000;
            if (!rst) begin
                if (m_vec > 0) begin
                    ph = VEC - m_vec;
                    e_rd = (ph == 0) || (ph == 2);
                    if (e_rd) e_addr = (ph == 0) ? 16'hFFFC : 16'hFFFD;
                end else begin
                    e_vld = (m_age >= 2 * l);
                    e_rd  = !e_vld && (m_age % 2 == 0);
                    if (e_rd) e_addr = m_pc + 16'(m_age / 2);
                end
            end
            chk("mem_rd", 32'(mem_rd), 32'(e_rd));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("inst_valid", 32'(inst_valid), 32'(e_vld));
            if (inst_valid && q.size() > 0) begin
                chk("inst_opcode", 32'(inst_opcode), 32'(q[0].op));
                chk("inst_op1", 32'(inst_op1), 32'(q[0].op1));
                chk("inst_op2", 32'(inst_op2), 32'(q[0].op2));
                chk("inst_len", 32'(inst_len), 32'(q[0].len));
                chk("inst_pc", 32'(inst_pc), 32'(q[0].pc));
                chk("dec_opcode_hold", 32'(dec_opcode), 32'(q[0].op));
                if (inst_ready) void'(q.pop_front());
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[START + 16'd0] = 8'hEA;
        mem[START + 16'd1] = 8'hE8;
        mem[START + 16'd2] = 8'hAD;
        mem[START + 16'd3] = 8'h34;
        mem[START + 16'd4] = 8'h12;
        mem[START + 16'd5] = 8'hA9;
        mem[START + 16'd6] = 8'h55;
        mem[16'hFFFE] = 8'h4C;
        mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'h80;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'hC0;

        // Reset values
        cyc(2);
        mon_en = 1;
        @(negedge clk);
        chk("rst_inst_opcode", 32'(inst_opcode), 0);
        chk("rst_inst_op1", 32'(inst_op1), 0);
        chk("rst_inst_op2", 32'(inst_op2), 0);
        chk("rst_inst_len", 32'(inst_len), 0);
        chk("rst_inst_pc", 32'(inst_pc), 0);
        chk("rst_dec_opcode", 32'(dec_opcode), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Sequential program with ready high until the 2-byte A9 55 is being fetched,
        // then back-pressure for well over five cycles of presentation.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            if (m_vec == 0 && m_pc == START + 16'd5) found = 1;
        end
        chk("reach_a9", 32'(found), 1);
        inst_ready = 1'b0;
        cyc(10);
        inst_ready = 1'b1;
        cyc(20);

        // Redirect while the first operand byte is being captured.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc();
            if (m_vec == 0 && m_age == 3 && norm_len(m_pc) >= 2) found = 1;
        end
        chk("reach_b1_cap", 32'(found), 1);
        redirect_valid = 1'b1; redirect_pc = 16'h2000;
        cyc();
        redirect_valid = 1'b0;
        cyc(20);

        // Wrap: 3-byte op at FFFE reads FFFF then 0000, next pc 0001.
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        cyc();
        redirect_valid = 1'b0;
        cyc(8);
        chk("wrap_next_pc", 32'(m_pc), 32'h0001);
        cyc(10);

        // Reset in the middle of an operand fetch.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc();
            if (m_vec == 0 && m_age == 4 && norm_len(m_pc) == 3) found = 1;
        end
        chk("reach_b2_req", 32'(found), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_inst_opcode", 32'(inst_opcode), 0);
        chk("midrst_inst_pc", 32'(inst_pc), 0);
        cyc(20);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            inst_ready     = ($urandom % 10) < 7;
            redirect_valid = ($urandom % 25) == 0;
            redirect_pc    = 16'($urandom);
            rst            = ($urandom % 700) == 0;
            cyc();
        end
        rst = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
        cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
